ps2_keyboard_rx: RTL and testbench

- PS/2 keyboard receiver that produces the keyb_char word read by the CPU at address 0x1003_0000 through the memory mapper.
- Deserialises PS/2 frames, checks framing and parity, and resolves E0 (extended) and F0 (break) prefixes.
- Holds the most recently pressed key code until that key is released, so software can poll key-held state (for example, hold-to-jump).
- Sits directly upstream of the memory mapper's keyboard read path.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_keyboard_rx_edge_filter.sv | 53 +++++
 rtl/ps2_keyboard_rx.sv | 158 +++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   ps2_state_t : frame receiver FSM states
//   SC_EXT      : extended-key prefix byte
//   SC_BREAK    : key-release prefix byte
//   EXT_BIT     : position of the extended flag within keyb_char
//   CODE_MSB    : top bit of the scancode field within keyb_char
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    localparam int unsigned EXT_BIT  = 8;
    localparam int unsigned CODE_MSB = 7;

endpackage

// File: rtl/ps2_keyboard_rx_edge_filter.sv
// ps2_edge_filter: conditions a raw asynchronous PS/2 clock line.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   raw    : raw asynchronous input line
//   level  : filtered level (resets to 1, the idle bus level)
//   fall   : one-cycle pulse on a filtered 1->0 transition
// The filtered level only follows the synchronised input after FILTER_LEN
// consecutive samples that differ from the current filtered level.
module ps2_edge_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run_cnt;
    logic          run_done;

    assign run_done = (sync2 != level) && (run_cnt == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            run_cnt <= '0;
            level   <= 1'b1;
            fall    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                run_cnt <= '0;
            end else if (run_done) begin
                run_cnt <= '0;
                level   <= sync2;
                // fall is registered alongside the level change so it lines
                // up with the cycle on which the new low level is visible.
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver feeding the memory-mapped
// keyb_char word (CPU address 0x1003_0000).
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   ps2_clk   : raw PS/2 clock from the keyboard
//   ps2_data  : raw PS/2 data from the keyboard
//   keyb_char : {zeros, ext, scancode[7:0]} of the key currently held, 0 if none
//   frame_err : one-cycle pulse on start/parity/stop error or frame timeout
// The last make code is held until its matching break arrives, so software
// can poll whether a key is still down.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned wordsize       = 32,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [wordsize-1:0] keyb_char,
    output logic                frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic ps2_clk_level;
    logic fall;
    logic data_s1;
    logic data_s2;

    ps2_edge_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk),
        .level (ps2_clk_level),
        .fall  (fall)
    );

    ps2_state_t          state,     state_n;
    logic [2:0]          bitcnt,    bitcnt_n;
    logic [7:0]          shreg,     shreg_n;
    logic                par_bit,   par_bit_n;
    logic                ext,       ext_n;
    logic                brk,       brk_n;
    logic [TW-1:0]       tcount,    tcount_n;
    logic [wordsize-1:0] keyb_n;
    logic                frame_err_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_s1   <= 1'b1;
            data_s2   <= 1'b1;
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            tcount    <= '0;
            keyb_char <= '0;
            frame_err <= 1'b0;
        end else begin
            data_s1   <= ps2_data;
            data_s2   <= data_s1;
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            par_bit   <= par_bit_n;
            ext       <= ext_n;
            brk       <= brk_n;
            tcount    <= tcount_n;
            keyb_char <= keyb_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        bitcnt_n    = bitcnt;
        shreg_n     = shreg;
        par_bit_n   = par_bit;
        ext_n       = ext;
        brk_n       = brk;
        tcount_n    = tcount;
        keyb_n      = keyb_char;
        frame_err_n = 1'b0;

        if (fall) begin
            // A fall always restarts the timeout, even on the expiry cycle.
            tcount_n = '0;
            unique case (state)
                IDLE: begin
                    if (!data_s2) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
                DATA: begin
                    shreg_n  = {data_s2, shreg[7:1]};
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_bit_n = data_s2;
                    state_n   = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (data_s2 && (^{shreg, par_bit})) begin
                        if (shreg == SC_EXT) begin
                            ext_n = 1'b1;
                        end else if (shreg == SC_BREAK) begin
                            brk_n = 1'b1;
                        end else if (brk) begin
                            // Only the release of the held key clears it.
                            if (keyb_char[EXT_BIT:0] == {ext, shreg}) begin
                                keyb_n = '0;
                            end
                            ext_n = 1'b0;
                            brk_n = 1'b0;
                        end else begin
                            keyb_n                = '0;
                            keyb_n[EXT_BIT]       = ext;
                            keyb_n[CODE_MSB:0]    = shreg;
                            ext_n                 = 1'b0;
                        end
                    end else begin
                        frame_err_n = 1'b1;
                        ext_n       = 1'b0;
                        brk_n       = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
                state_n     = IDLE;
                tcount_n    = '0;
                frame_err_n = 1'b1;
                ext_n       = 1'b0;
                brk_n       = 1'b0;
            end else begin
                tcount_n = tcount + 1'b1;
            end
        end else begin
            tcount_n = '0;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;

    localparam int unsigned FILTER_LEN     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 2000;

    logic        clk;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] keyb_char;
    logic        frame_err;

    int unsigned checks;
    int unsigned errors;
    int unsigned cyc;
    int unsigned fall_drive_cyc;
    int unsigned err_pulses;
    int unsigned err_double;
    logic        err_prev;

    ps2_keyboard_rx #(
        .wordsize       (32),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keyb_char (keyb_char),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Counts distinct frame_err pulses and any pulse wider than one cycle.
    always @(negedge clk) begin
        if (frame_err && !err_prev) err_pulses++;
        if (frame_err && err_prev)  err_double++;
        err_prev = frame_err;
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(50);
        ps2_clk = 1'b0;
        fall_drive_cyc = cyc;
        wait_clks(100);
        ps2_clk = 1'b1;
        wait_clks(50);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ flip_parity);
        send_bit(1'b1);
        ps2_data = 1'b1;
    endtask

    task automatic test_reset;
        if (keyb_char !== 32'h0) begin
            $display("FAIL reset_keyb: got %h expected %h", keyb_char, 32'h0);
            errors++;
        end
        checks++;
        if (frame_err !== 1'b0) begin
            $display("FAIL reset_err: got %b expected 0", frame_err);
            errors++;
        end
        checks++;
    endtask

    task automatic test_make_break;
        int unsigned e0;
        e0 = err_pulses;
        send_frame(8'h29, 1'b0);
        if (keyb_char !== 32'h0000_0029) begin
            $display("FAIL make_29: got %h expected %h", keyb_char, 32'h29);
            errors++;
        end
        checks++;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        if (keyb_char !== 32'h0) begin
            $display("FAIL break_29: got %h expected %h", keyb_char, 32'h0);
            errors++;
        end
        checks++;
        if (err_pulses !== e0) begin
            $display("FAIL make_break_err: got %0d pulses expected %0d", err_pulses, e0);
            errors++;
        end
        checks++;
    endtask

    task automatic test_extended;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        if (keyb_char !== 32'h0000_0175) begin
            $display("FAIL ext_make: got %h expected %h", keyb_char, 32'h175);
            errors++;
        end
        checks++;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        if (keyb_char !== 32'h0) begin
            $display("FAIL ext_break: got %h expected %h", keyb_char, 32'h0);
            errors++;
        end
        checks++;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        if (keyb_char !== 32'h0000_0175) begin
            $display("FAIL ext_remake: got %h expected %h", keyb_char, 32'h175);
            errors++;
        end
        checks++;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        if (keyb_char !== 32'h0000_0175) begin
            $display("FAIL ext_other_release: got %h expected %h", keyb_char, 32'h175);
            errors++;
        end
        checks++;
    endtask

    task automatic test_parity_error;
        int unsigned e0;
        int unsigned d0;
        e0 = err_pulses;
        d0 = err_double;
        send_frame(8'h1D, 1'b1);
        if (err_pulses !== e0 + 1) begin
            $display("FAIL parity_err_pulse: got %0d pulses expected %0d", err_pulses - e0, 1);
            errors++;
        end
        checks++;
        if (err_double !== d0) begin
            $display("FAIL parity_err_width: got %0d extra cycles expected 0", err_double - d0);
            errors++;
        end
        checks++;
        if (keyb_char !== 32'h0000_0175) begin
            $display("FAIL parity_keep: got %h expected %h", keyb_char, 32'h175);
            errors++;
        end
        checks++;
        send_frame(8'h1D, 1'b0);
        if (keyb_char !== 32'h0000_001D) begin
            $display("FAIL parity_recover: got %h expected %h", keyb_char, 32'h1D);
            errors++;
        end
        checks++;
    endtask

    task automatic test_timeout;
        int unsigned e0;
        int unsigned n;
        int unsigned delta;
        logic [7:0]  partial;
        partial = 8'h29;
        e0 = err_pulses;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        ps2_data = 1'b1;
        n = 0;
        while (frame_err !== 1'b1 && n < 3000) begin
            wait_clks(1);
            n++;
        end
        delta = cyc - fall_drive_cyc;
        if (frame_err !== 1'b1) begin
            $display("FAIL timeout_seen: got no pulse expected frame_err=1 within budget");
            errors++;
        end
        checks++;
        // Drive-to-fall latency is 2 sync + FILTER_LEN filter + 1 register.
        if (delta < TIMEOUT_CYCLES || delta > TIMEOUT_CYCLES + 15) begin
            $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d",
                     delta, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 15);
            errors++;
        end
        checks++;
        wait_clks(20);
        if (err_pulses !== e0 + 1) begin
            $display("FAIL timeout_pulses: got %0d expected %0d", err_pulses - e0, 1);
            errors++;
        end
        checks++;
        if (keyb_char !== 32'h0000_001D) begin
            $display("FAIL timeout_keep: got %h expected %h", keyb_char, 32'h1D);
            errors++;
        end
        checks++;
        send_frame(8'h29, 1'b0);
        if (keyb_char !== 32'h0000_0029) begin
            $display("FAIL timeout_recover: got %h expected %h", keyb_char, 32'h29);
            errors++;
        end
        checks++;
    endtask

    task automatic test_glitch;
        int unsigned e0;
        e0 = err_pulses;
        ps2_clk = 1'b0;
        wait_clks(2);
        ps2_clk = 1'b1;
        wait_clks(50);
        if (err_pulses !== e0) begin
            $display("FAIL glitch_err: got %0d pulses expected 0", err_pulses - e0);
            errors++;
        end
        checks++;
        if (keyb_char !== 32'h0000_0029) begin
            $display("FAIL glitch_keep: got %h expected %h", keyb_char, 32'h29);
            errors++;
        end
        checks++;
        // A real frame right after the glitch must still decode cleanly.
        send_frame(8'h29, 1'b0);
        if (keyb_char !== 32'h0000_0029 || err_pulses !== e0) begin
            $display("FAIL glitch_next_frame: got %h/%0d expected %h/%0d",
                     keyb_char, err_pulses - e0, 32'h29, 0);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_frame;
        int unsigned e0;
        logic [7:0]  partial;
        partial = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(partial[i]);
        ps2_data = partial[3];
        wait_clks(20);
        #2;
        reset = 1'b1;
        #1;
        if (keyb_char !== 32'h0) begin
            $display("FAIL reset_async: got %h expected %h", keyb_char, 32'h0);
            errors++;
        end
        checks++;
        wait_clks(3);
        reset = 1'b0;
        ps2_data = 1'b1;
        wait_clks(100);
        e0 = err_pulses;
        send_frame(8'h1C, 1'b0);
        if (keyb_char !== 32'h0000_001C) begin
            $display("FAIL reset_recover: got %h expected %h", keyb_char, 32'h1C);
            errors++;
        end
        checks++;
        if (err_pulses !== e0) begin
            $display("FAIL reset_recover_err: got %0d pulses expected 0", err_pulses - e0);
            errors++;
        end
        checks++;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        fall_drive_cyc = 0;
        err_pulses     = 0;
        err_double     = 0;
        err_prev       = 1'b0;
        reset          = 1'b1;
        ps2_clk        = 1'b1;
        ps2_data       = 1'b1;
        wait_clks(5);
        test_reset;
        reset = 1'b0;
        wait_clks(20);
        test_make_break;
        test_extended;
        test_parity_error;
        test_timeout;
        test_glitch;
        test_reset_mid_frame;
        if (err_double !== 0) begin
            $display("FAIL err_single_cycle: got %0d wide cycles expected 0", err_double);
            errors++;
        end
        checks++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
